// File: rtl/decryption_pkg.sv
// Shared defaults and width-generic rotate helpers for the decryption pipeline.
// Rotates operate on the low w bits of a MAXW-wide container; callers cast back to their width.
package decryption_pkg;

  localparam int DEF_N      = 8;
  localparam int DEF_ROUNDS = 2;
  localparam int DEF_ROT    = 3;
  localparam int MAXW       = 64;

  // Shift amounts >= MAXW yield zero, so the s == 0 case falls out of the mask.
  function automatic logic [MAXW-1:0] rotr(input logic [MAXW-1:0] x, input int n, input int w);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] xm;
    int              s;
    mask = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    xm   = x & mask;
    s    = n % w;
    return ((xm >> s) | (xm << (w - s))) & mask;
  endfunction

  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] x, input int n, input int w);
    return rotr(x, (w - (n % w)) % w, w);
  endfunction

endpackage

// File: rtl/decryption_round.sv
// One inverse round (rotate right, then XOR round key), registered together with its key.
// Latency 1 cycle; no backpressure, accepts a word every edge.
module decryption_round
  import decryption_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int ROT  = DEF_ROT,
  parameter int RIDX = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] key_in,
  input  logic [N-1:0] x_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] x_out
);

  logic [N-1:0] round_key;
  logic [N-1:0] x_next;

  assign round_key = N'(rotl(MAXW'(key_in), RIDX, N));
  assign x_next    = N'(rotr(MAXW'(x_in), ROT, N)) ^ round_key;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_out <= '0;
      x_out   <= '0;
    end else begin
      key_out <= key_in;
      x_out   <= x_next;
    end
  end

endmodule

// File: rtl/decryption.sv
// Pipelined block decryptor: ROUNDS registered inverse rounds, key travels with each word.
// Latency ROUNDS edges; no backpressure, one word per clock.
module decryption
  import decryption_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int ROT    = DEF_ROT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] key,
  input  logic [N-1:0] e_data,
  output logic [N-1:0] data
);

  logic [N-1:0] keys [0:ROUNDS];
  logic [N-1:0] xs   [0:ROUNDS];

  assign keys[0] = key;
  assign xs[0]   = e_data;

  // Stage i undoes encryption round ROUNDS-1-i, so rounds peel off in reverse order.
  for (genvar i = 0; i < ROUNDS; i++) begin : g_round
    decryption_round #(
      .N   (N),
      .ROT (ROT),
      .RIDX(ROUNDS - 1 - i)
    ) u_round (
      .clock  (clock),
      .reset  (reset),
      .key_in (keys[i]),
      .x_in   (xs[i]),
      .key_out(keys[i+1]),
      .x_out  (xs[i+1])
    );
  end

  assign data = xs[ROUNDS];

  // The key leaving the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^keys[ROUNDS];

endmodule

// File: tb/tb_decryption.sv
// Bench for decryption: directed vectors plus an encrypt-model round trip, checked every cycle.
module tb_decryption;

  localparam int N      = 8;
  localparam int ROUNDS = 2;
  localparam int ROT    = 3;
  localparam int MAXE   = 1200;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] key;
  logic [7:0] e_data;
  logic [7:0] data;

  decryption #(.N(N), .ROUNDS(ROUNDS), .ROT(ROT)) dut (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .e_data(e_data),
    .data  (data)
  );

  always #5 clock = ~clock;

  // Per-edge record of what was driven: reset level and the plaintext that word should decode to.
  logic       rst_h [MAXE];
  logic [7:0] exp_h [MAXE];
  int         nxt    = 0;
  int         checks = 0;
  int         passed = 0;
  bit         done   = 1'b0;

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    int s;
    s = n % 8;
    return (s == 0) ? x : ((x << s) | (x >> (8 - s)));
  endfunction

  // Forward cipher; the DUT must invert it.
  function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k);
    logic [7:0] x;
    x = p;
    for (int r = 0; r < ROUNDS; r++) x = rl8(x ^ rl8(k, r), ROT);
    return x;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s edge %0d: got %02h, expected %02h", name, cyc, got, want);
  endtask

  task automatic step(input logic r, input logic [7:0] k, input logic [7:0] e, input logic [7:0] p);
    reset  = r;
    key    = k;
    e_data = e;
    rst_h[nxt] = r;
    exp_h[nxt] = p;
    @(posedge clock);
    #1;
    nxt++;
  endtask

  // Word from edge t-1 is visible after edge t, unless reset hit either edge.
  int         cmp_t;
  logic [7:0] cmp_exp;
  always @(negedge clock) begin
    if (nxt > 0 && !done) begin
      cmp_t = nxt - 1;
      if (rst_h[cmp_t] || cmp_t == 0) cmp_exp = 8'h00;
      else if (rst_h[cmp_t-1])        cmp_exp = 8'h00;
      else                            cmp_exp = exp_h[cmp_t-1];
      chk("data", cmp_t, data, cmp_exp);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got edge %0d, expected at most %0d", nxt, MAXE);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] p, k;

    chk("enc_model_a", -1, enc(8'h04, 8'h00), 8'h01);
    chk("enc_model_b", -1, enc(8'hC4, 8'h0F), 8'h02);
    chk("enc_model_c", -1, enc(8'h55, 8'hAA), 8'h55);

    step(1'b1, 8'h5A, 8'hC3, 8'h00);
    step(1'b1, 8'hFF, 8'h81, 8'h00);

    // Isolated vectors separated by an all-zero word (decodes to zero).
    step(1'b0, 8'h00, 8'h01, 8'h04);
    step(1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 8'h0F, 8'h02, 8'hC4);
    step(1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 8'hAA, 8'h55, 8'h55);
    step(1'b0, 8'h00, 8'h00, 8'h00);

    // Back-to-back with the key changing every word.
    step(1'b0, 8'h00, 8'h01, 8'h04);
    step(1'b0, 8'h0F, 8'h02, 8'hC4);
    step(1'b0, 8'hAA, 8'h55, 8'h55);

    for (int i = 0; i < 5; i++) begin
      p = 8'($urandom); k = 8'($urandom);
      step(1'b0, k, enc(p, k), p);
    end

    // Single-edge reset with words in flight.
    step(1'b1, 8'h3C, 8'h77, 8'h00);

    for (int i = 0; i < 1000; i++) begin
      p = 8'($urandom); k = 8'($urandom);
      step(1'b0, k, enc(p, k), p);
    end

    step(1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00, 8'h00);

    @(negedge clock);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
